// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID read master.
// States, error codes, slave word addresses and the result check.
package sysid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    DONE
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // ID mismatch wins over timestamp mismatch
  function automatic logic [1:0] check_words(
    input logic [31:0] id,
    input logic [31:0] ts,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts
  );
    logic [1:0] code;
    code = ERR_OK;
    if (id != exp_id) begin
      code = ERR_ID;
    end else if (ts != exp_ts) begin
      code = ERR_TS;
    end
    return code;
  endfunction

endpackage

// File: rtl/sysid_read_master.sv
// Avalon-MM master that reads the system-ID slave (ID, timestamp)
// and checks both words against the expected build values.
module sysid_read_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1361656172,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        av_read_q, av_read_d;
  logic        av_addr_q, av_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        to_hit;
  logic [1:0]  chk;

  // The stalled cycle that brings the count to the limit aborts
  assign to_hit = ({1'b0, cnt_q} + 17'd1) >= TO_LIM;
  assign chk = check_words(id_value_q, av_readdata,
                           EXPECTED_ID, EXPECTED_TIMESTAMP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    err_d      = err_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          cnt_d   = '0;
        end
      end
      RD_ID: begin
        if (!av_waitrequest) begin
          id_value_d = av_readdata;
          state_d    = RD_TS;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (to_hit) begin
            state_d = DONE;
            err_d   = ERR_TIMEOUT;
            pass_d  = 1'b0;
          end
        end
      end
      RD_TS: begin
        if (!av_waitrequest) begin
          ts_value_d = av_readdata;
          err_d      = chk;
          pass_d     = (chk == ERR_OK);
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (to_hit) begin
            state_d = DONE;
            err_d   = ERR_TIMEOUT;
            pass_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Bus strobes and status are registered from the next state
    av_read_d = (state_d == RD_ID) || (state_d == RD_TS);
    av_addr_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
    busy_d    = av_read_d;
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      av_read_q  <= 1'b0;
      av_addr_q  <= ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= ERR_OK;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      av_read_q  <= av_read_d;
      av_addr_q  <= av_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign av_read    = av_read_q;
  assign av_address = av_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err        = err_q;
  assign id_value   = id_value_q;
  assign ts_value   = ts_value_q;

endmodule

// File: tb/tb_sysid_read_master.sv
// Bench for sysid_read_master: behavioural slave with programmable
// stalls, expected results queued at start and checked at done.
module tb_sysid_read_master;

  localparam int TO = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1361656172;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_read_master #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .av_address(av_address),
    .av_read(av_read),
    .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err(err),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stalls each read for wait_id / wait_ts cycles
  int          wait_id = 0;
  int          wait_ts = 0;
  int          wcnt = 0;
  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = 32'd1361656172;

  assign av_readdata = av_address ? ts_word : id_word;
  assign av_waitrequest =
    av_read && (wcnt < (av_address ? wait_ts : wait_id));

  always @(posedge clock) begin
    if (!av_read || !av_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int done_cnt = 0;
  always @(posedge clock) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [1:0]  err;
    logic        pass;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;
  int errors = 0;
  int checks = 0;

  // Reference outcome of one check from the slave configuration
  task automatic push_expected();
    exp_t e;
    if (wait_id >= TO) begin
      e.err = 2'b11;
      e.lat = 1 + TO;
    end else begin
      m_id = id_word;
      if (wait_ts >= TO) begin
        e.err = 2'b11;
        e.lat = 1 + wait_id + 1 + TO;
      end else begin
        m_ts = ts_word;
        e.lat = 1 + wait_id + 1 + wait_ts + 1;
        if (id_word != EXP_ID) e.err = 2'b01;
        else if (ts_word != EXP_TS) e.err = 2'b10;
        else e.err = 2'b00;
      end
    end
    e.pass = (e.err == 2'b00);
    e.id = m_id;
    e.ts = m_ts;
    sb_q.push_back(e);
  endtask

  task automatic run_op(input string name, input bit pulse_busy,
                        input bit pulse_done);
    exp_t e;
    int k;
    int dc0;
    logic prev_rd, prev_wr, prev_addr;
    prev_rd = 0;
    prev_wr = 0;
    prev_addr = 0;
    @(negedge clock);
    dc0 = done_cnt;
    push_expected();
    start = 1'b1;
    k = 0;
    while (!done && k < 300) begin
      @(negedge clock);
      k++;
      start = pulse_busy && (k == 1);
      if (!done && prev_rd && prev_wr && av_read) begin
        checks++;
        if (av_address !== prev_addr) begin
          errors++;
          $display("FAIL %s addr_hold cyc=%0d got=%0b want=%0b",
                   name, k, av_address, prev_addr);
        end
      end
      prev_rd = av_read;
      prev_wr = av_waitrequest;
      prev_addr = av_address;
    end
    e = sb_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout got=%0b want=1", name, done);
    end
    checks++;
    if (k !== e.lat) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d", name, k, e.lat);
    end
    checks++;
    if (err !== e.err) begin
      errors++;
      $display("FAIL %s err got=%b want=%b", name, err, e.err);
    end
    checks++;
    if (pass !== e.pass) begin
      errors++;
      $display("FAIL %s pass got=%b want=%b", name, pass, e.pass);
    end
    checks++;
    if (id_value !== e.id) begin
      errors++;
      $display("FAIL %s id_value got=%h want=%h", name, id_value, e.id);
    end
    checks++;
    if (ts_value !== e.ts) begin
      errors++;
      $display("FAIL %s ts_value got=%h want=%h", name, ts_value, e.ts);
    end
    checks++;
    if (busy !== 1'b0 || av_read !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle busy=%b av_read=%b want 0 0",
               name, busy, av_read);
    end
    start = pulse_done;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || av_read !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done done=%b av_read=%b want 0 0",
               name, done, av_read);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (done_cnt - dc0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s one_done pulses=%0d busy=%b want 1 0",
               name, done_cnt - dc0, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({av_read, av_address, busy, done, pass} !== 5'b0) begin
      errors++;
      $display("FAIL reset ctrl got=%b want=00000",
               {av_read, av_address, busy, done, pass});
    end
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL reset err got=%b want=00", err);
    end
    checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset words got=%h/%h want=0/0", id_value, ts_value);
    end
  endtask

  task automatic test_zero_wait();
    wait_id = 0;
    wait_ts = 0;
    id_word = EXP_ID;
    ts_word = EXP_TS;
    run_op("zero_wait", 0, 0);
  endtask

  task automatic test_stalls();
    wait_id = 2;
    wait_ts = 2;
    run_op("stalls", 0, 0);
    wait_id = 0;
    wait_ts = 0;
  endtask

  task automatic test_mismatch();
    ts_word = 32'h12345678;
    run_op("ts_mismatch", 0, 0);
    id_word = 32'hDEAD;
    run_op("id_mismatch", 0, 0);
    id_word = EXP_ID;
    ts_word = EXP_TS;
  endtask

  task automatic test_timeout();
    id_word = 32'h0;
    ts_word = 32'hCAFE0001;
    wait_ts = 1000;
    run_op("timeout_ts", 0, 0);
    wait_id = 1000;
    run_op("timeout_id", 0, 0);
    wait_id = 0;
    wait_ts = 0;
    ts_word = EXP_TS;
  endtask

  task automatic test_reset_mid();
    int dc0;
    wait_ts = 1000;
    @(negedge clock);
    dc0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (av_read !== 1'b1 || av_address !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid stalled got=%b%b want=11",
               av_read, av_address);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({av_read, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid outs got=%b want=00000",
               {av_read, busy, done, err});
    end
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (4) @(negedge clock);
    checks++;
    if (done_cnt !== dc0) begin
      errors++;
      $display("FAIL reset_mid no_done got=%0d want=%0d", done_cnt, dc0);
    end
    wait_ts = 0;
    run_op("after_reset", 0, 0);
  endtask

  task automatic test_ignore_start();
    ts_word = 32'h0BADF00D;
    run_op("ignore_start", 1, 1);
    ts_word = EXP_TS;
    run_op("back_to_back", 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_zero_wait();
    test_stalls();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_ignore_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
